seq_mac_neuron: RTL and testbench

Parametrised, clocked successor to the combinational single-output neuron.
- Accepts a vector of N_IN unsigned inputs, signed fixed-point weights and an unsigned bias through a valid/ready handshake.
- Accumulates one weighted input per cycle, adds the bias, then applies a selectable activation: piecewise-linear sigmoid or clipped ReLU.
- Sits between hidden/output layer stages of the network and produces an 8-bit Q0.8 activation plus the raw pre-activation sum.

---
 rtl/neuron_pkg.sv | 16 +
 rtl/act_plan_sigmoid.sv | 23 ++
 rtl/seq_mac_neuron.sv | 102 ++++++++++
 tb/tb_seq_mac_neuron.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: fixed-point constants, PLAN sigmoid segment table, FSM states and activation encodings.
package neuron_pkg;
  localparam int FRAC_BITS = 4;
  localparam int ACT_FRAC = 8;
  localparam int ACT_SIGMOID = 0;
  localparam int ACT_RELU = 1;
  // Breakpoints on |x| and segment offsets, all Q8.8
  localparam logic [31:0] PLAN_X1 = 32'd256;
  localparam logic [31:0] PLAN_X2 = 32'd608;
  localparam logic [31:0] PLAN_X3 = 32'd1280;
  localparam logic [31:0] PLAN_ONE = 32'd256;
  localparam logic [31:0] PLAN_C1 = 32'd128;
  localparam logic [31:0] PLAN_C2 = 32'd160;
  localparam logic [31:0] PLAN_C3 = 32'd216;
  typedef enum logic [1:0] {IDLE, MAC, ACT, HOLD} neuron_state_t;
endpackage

// File: rtl/act_plan_sigmoid.sv
// act_plan_sigmoid: combinational Q.4 -> Q0.8 activation, PLAN sigmoid or clipped ReLU.
module act_plan_sigmoid
  import neuron_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic                    i_mode,
  output logic [7:0]              o_act
);
  logic [ACC_W-1:0] w_mag;
  logic [31:0] w_x, w_f, w_r;
  assign w_mag = i_acc[ACC_W-1] ? -i_acc : i_acc;
  // |x| rescaled from Q.4 to Q8.8 so segment slopes become plain shifts
  assign w_x = 32'(w_mag) << FRAC_BITS;
  assign w_f = w_x >= PLAN_X3 ? PLAN_ONE :
               w_x >= PLAN_X2 ? (w_x >> 5) + PLAN_C3 :
               w_x >= PLAN_X1 ? (w_x >> 3) + PLAN_C2 :
                                (w_x >> 2) + PLAN_C1;
  assign w_r = i_acc[ACC_W-1] ? PLAN_ONE - w_f : w_f;
  assign o_act = i_mode ? (i_acc[ACC_W-1] ? 8'd0 : w_x > 32'd255 ? 8'd255 : w_x[7:0])
                        : (w_r > 32'd255 ? 8'd255 : w_r[7:0]);
endmodule

// File: rtl/seq_mac_neuron.sv
// seq_mac_neuron: sequential saturating MAC neuron with bias and selectable activation.
module seq_mac_neuron
  import neuron_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int IN_W = 2,
  parameter int W_W = 8,
  parameter int B_W = 3,
  parameter int ACC_W = 16,
  parameter int ACT_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_vec,
  input  logic [N_IN*W_W-1:0]    w_vec,
  input  logic [B_W-1:0]         bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_act,
  output logic [ACC_W-1:0]       out_sum,
  output logic                   out_sat
);
  localparam int P_W = IN_W + W_W;
  localparam int S_W = (ACC_W > P_W ? ACC_W : P_W) + 1;
  localparam int I_W = $clog2(N_IN + 1);
  localparam logic [I_W-1:0] LAST = I_W'(N_IN - 1);
  neuron_state_t r_state, w_next;
  logic [N_IN*IN_W-1:0] r_in;
  logic [N_IN*W_W-1:0] r_w;
  logic [I_W-1:0] r_idx;
  logic signed [ACC_W-1:0] r_acc, w_acc;
  logic [IN_W-1:0] w_x;
  logic [W_W-1:0] w_wt;
  logic signed [P_W-1:0] w_prod;
  logic signed [S_W-1:0] w_sum;
  logic w_ovf;
  logic [7:0] w_act, r_act;
  logic [ACC_W-1:0] r_sum;
  logic r_valid, r_sat;
  assign w_x = r_in[r_idx*IN_W +: IN_W];
  assign w_wt = r_w[r_idx*W_W +: W_W];
  assign w_prod = $signed({{W_W{1'b0}}, w_x}) * $signed({{IN_W{w_wt[W_W-1]}}, w_wt});
  assign w_sum = S_W'(r_acc) + S_W'(w_prod);
  // Overflow when the bits above the ACC_W sign bit disagree with it
  assign w_ovf = ~(&w_sum[S_W-1:ACC_W-1] | ~|w_sum[S_W-1:ACC_W-1]);
  assign w_acc = !w_ovf ? w_sum[ACC_W-1:0] :
                 w_sum[S_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  assign in_ready = r_state == IDLE;
  assign out_valid = r_valid;
  assign out_act = r_act;
  assign out_sum = r_sum;
  assign out_sat = r_sat;
  act_plan_sigmoid #(.ACC_W(ACC_W)) u_act (
    .i_acc (r_acc),
    .i_mode(ACT_MODE == ACT_RELU),
    .o_act (w_act)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = in_valid ? MAC : IDLE;
      MAC:     w_next = r_idx == LAST ? ACT : MAC;
      ACT:     w_next = HOLD;
      HOLD:    w_next = out_ready ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in <= '0;
      r_w <= '0;
      r_idx <= '0;
      r_acc <= '0;
      r_act <= '0;
      r_sum <= '0;
      r_valid <= 1'b0;
      r_sat <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_in <= in_vec;
      r_w <= w_vec;
      r_idx <= '0;
      r_acc <= ACC_W'({bias, {FRAC_BITS{1'b0}}});
      r_sat <= 1'b0;
    end else if (r_state == MAC) begin
      r_acc <= w_acc;
      r_sat <= r_sat | w_ovf;
      r_idx <= r_idx + 1'b1;
    end else if (r_state == ACT) begin
      r_act <= w_act;
      r_sum <= r_acc;
      r_valid <= 1'b1;
    end else if (r_state == HOLD && out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_mac_neuron.sv
// tb_seq_mac_neuron: scoreboard bench driving three neuron variants (sigmoid, ReLU, 8-bit acc) in lockstep.
module tb_seq_mac_neuron;
  typedef struct {int sum; int act; bit sat;} exp_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [5:0] in_vec = 0;
  logic [23:0] w_vec = 0;
  logic [2:0] bias = 0;
  logic v[3], r[3], st[3];
  logic [7:0] a[3];
  logic signed [15:0] s0, s1;
  logic signed [7:0] s2;
  int sv[3];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit rr_en = 1, pv = 0;
  logic rr_val = 1;
  exp_t q[3][$];
  int lat_q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    out_ready = rr_en ? (($urandom % 3) != 0) : rr_val;
  end
  always_comb begin
    sv[0] = int'(s0);
    sv[1] = int'(s1);
    sv[2] = int'(s2);
  end

  seq_mac_neuron u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r[0]), .in_vec(in_vec),
    .w_vec(w_vec), .bias(bias), .out_valid(v[0]), .out_ready(out_ready), .out_act(a[0]), .out_sum(s0), .out_sat(st[0]));
  seq_mac_neuron #(.ACT_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r[1]), .in_vec(in_vec),
    .w_vec(w_vec), .bias(bias), .out_valid(v[1]), .out_ready(out_ready), .out_act(a[1]), .out_sum(s1), .out_sat(st[1]));
  seq_mac_neuron #(.ACC_W(8)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r[2]), .in_vec(in_vec),
    .w_vec(w_vec), .bias(bias), .out_valid(v[2]), .out_ready(out_ready), .out_act(a[2]), .out_sum(s2), .out_sat(st[2]));

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [5:0] iv, input logic [23:0] wv, input logic [2:0] b,
                                 input int accw, input bit relu);
    exp_t o;
    int acc, mx, mn, fq, res;
    real x, ax, f;
    mx = (1 << (accw - 1)) - 1;
    mn = -(1 << (accw - 1));
    acc = int'(b) * 16;
    o.sat = 0;
    for (int i = 0; i < 3; i++) begin
      acc += int'(iv[i*2 +: 2]) * int'($signed(wv[i*8 +: 8]));
      if (acc > mx) begin acc = mx; o.sat = 1; end
      if (acc < mn) begin acc = mn; o.sat = 1; end
    end
    o.sum = acc;
    x = acc / 16.0;
    ax = x < 0 ? -x : x;
    if (relu) o.act = acc < 0 ? 0 : (acc * 16 > 255 ? 255 : acc * 16);
    else begin
      f = ax >= 5.0 ? 1.0 : ax >= 2.375 ? ax / 32 + 0.84375 : ax >= 1.0 ? ax / 8 + 0.625 : ax / 4 + 0.5;
      fq = int'($floor(f * 256.0));
      res = x < 0 ? 256 - fq : fq;
      o.act = res > 255 ? 255 : res;
    end
    return o;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) if (v[k] && out_ready) begin
        if (q[k].size() == 0) chk($sformatf("unexpected_out%0d", k), 1, 0);
        else begin
          e = q[k].pop_front();
          chk($sformatf("sum%0d", k), sv[k], e.sum);
          chk($sformatf("act%0d", k), int'(a[k]), e.act);
          chk($sformatf("sat%0d", k), int'(st[k]), int'(e.sat));
        end
      end
      if (v[0] && !pv) begin
        if (lat_q.size() == 0) chk("latency_no_accept", 1, 0);
        else chk("latency", cyc - lat_q.pop_front(), 4);
      end
    end
    pv <= v[0];
  end

  task automatic send(input logic [5:0] iv, input logic [23:0] wv, input logic [2:0] b);
    int k = 0;
    @(negedge clk);
    in_vec = iv; w_vec = wv; bias = b; in_valid = 1;
    while (!r[0] && k < 100) begin @(negedge clk); k++; end
    if (!r[0]) begin chk("accept_timeout", 0, 1); in_valid = 0; return; end
    @(posedge clk);
    #1;
    q[0].push_back(model(iv, wv, b, 16, 0));
    q[1].push_back(model(iv, wv, b, 16, 1));
    q[2].push_back(model(iv, wv, b, 8, 0));
    lat_q.push_back(cyc);
    in_valid = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q[0].size() || q[1].size() || q[2].size() || !r[0]) && k < 500) begin @(negedge clk); k++; end
    for (int j = 0; j < 3; j++) chk($sformatf("drain%0d", j), q[j].size(), 0);
  endtask

  logic [5:0] ti[6] = '{6'h00, 6'h15, 6'h15, 6'h3F, 6'h3F, 6'h00};
  logic [23:0] tw[6] = '{24'h101010, 24'h101010, 24'h000000, 24'hF0F0F0, 24'h7F7F7F, 24'h101010};
  logic [2:0] tb_[6] = '{3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0};
  logic [23:0] rw;
  logic [7:0] ea[3];
  int es[3];

  initial begin
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid%0d", k), int'(v[k]), 0);
      chk($sformatf("rst_ready%0d", k), int'(r[k]), 1);
      chk($sformatf("rst_act%0d", k), int'(a[k]), 0);
      chk($sformatf("rst_sum%0d", k), sv[k], 0);
      chk($sformatf("rst_sat%0d", k), int'(st[k]), 0);
    end
    rst_n = 1;
    for (int i = 0; i < 6; i++) send(ti[i], tw[i], tb_[i]);
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 3; i++) rw[i*8 +: 8] = ($urandom % 2) ? 8'($urandom) : 8'($urandom_range(0, 40) - 20);
      send(6'($urandom), rw, 3'($urandom));
    end
    drain();
    rr_en = 0; rr_val = 0;
    @(posedge clk); #3;
    send(6'h2A, 24'h0C1408, 3'd2);
    for (int k = 0; k < 20 && !v[0]; k++) @(negedge clk);
    chk("bp_valid_seen", int'(v[0]), 1);
    for (int k = 0; k < 3; k++) begin ea[k] = a[k]; es[k] = sv[k]; end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c == 4); in_vec = 6'h3F; w_vec = 24'h7F7F7F;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("bp_valid%0d", k), int'(v[k]), 1);
        chk($sformatf("bp_ready%0d", k), int'(r[k]), 0);
        chk($sformatf("bp_act%0d", k), int'(a[k]), int'(ea[k]));
        chk($sformatf("bp_sum%0d", k), sv[k], es[k]);
      end
    end
    in_valid = 0;
    rr_val = 1;
    repeat (3) @(negedge clk);
    chk("bp_release_ready", int'(r[0]), 1);
    chk("bp_release_valid", int'(v[0]), 0);
    chk("bp_queue_empty", q[0].size(), 0);
    repeat (10) @(negedge clk);
    rr_en = 1;
    send(6'h3F, 24'h101010, 3'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_rst_valid%0d", k), int'(v[k]), 0);
      chk($sformatf("mid_rst_ready%0d", k), int'(r[k]), 1);
      q[k].delete();
    end
    lat_q.delete();
    @(negedge clk);
    rst_n = 1;
    chk("post_rst_ready", int'(r[0]), 1);
    send(6'h15, 24'hF01010, 3'd3);
    send(6'h3F, 24'h7F7F7F, 3'd7);
    send(6'h00, 24'h000000, 3'd0);
    drain();
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
